// File: rtl/display_pkg.sv
// Shared types and helpers for the 4-digit scrolling 7-segment display controller.
package display_pkg;

  typedef enum logic {
    BLANK,
    DRIVE
  } slot_state_e;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam int         DIGITS    = 4;

  // Operands are always below m, so one conditional subtract replaces a divider.
  function automatic logic [31:0] mod_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] m);
    logic [31:0] s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/display_scroll_sequencer_button_edge.sv
// Two-flop synchroniser plus rising-edge pulse for the raw step button.
module button_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] vld_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  // Edges are qualified only once prev_q holds a genuine post-reset sample,
  // so a button held through reset never looks like a fresh press.
  assign rise_o = vld_q[2] & sync2_q & ~prev_q;

endmodule

// File: rtl/display_scroll_sequencer.sv
// Digit multiplexing with anti-ghosting blank plus message scroll pointer.
// Optional SCROLL_REVERSE_EN adds step_dir to scroll the message backwards.
module display_scroll_sequencer
  import display_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       step_button,
  input  logic                       mode_auto,
`ifdef SCROLL_REVERSE_EN
  input  logic                       step_dir,
`endif
  output logic [3:0]                 anode,
  output logic [1:0]                 digit_sel,
  output logic [$clog2(MSG_LEN)-1:0] char_index,
  output logic                       frame_start
);

  localparam int IDX_W  = $clog2(MSG_LEN);
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int SCR_W  = $clog2(SCROLL_DIV);

  slot_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0]        anode_q, anode_d;
  logic [IDX_W-1:0]  char_q, char_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic              pending_q, pending_d;
  logic [SCR_W-1:0]  scroll_cnt_q, scroll_cnt_d;

  logic        step_pulse;
  logic        scroll_tick;
  logic        advance_req;
  logic        frame_start_w;
  logic [31:0] base_step;

  button_edge u_button_edge (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (step_button),
    .rise_o (step_pulse)
  );

  assign scroll_tick   = mode_auto && (scroll_cnt_q == SCR_W'(SCROLL_DIV - 1));
  assign advance_req   = mode_auto ? scroll_tick : step_pulse;
  assign frame_start_w = !reset && (state_q == BLANK) && (digit_q == 2'd0)
                         && (slot_cnt_q == '0);

`ifdef SCROLL_REVERSE_EN
  assign base_step = step_dir ? 32'(MSG_LEN - 1) : 32'd1;
`else
  assign base_step = 32'd1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q + SLOT_W'(1);
    digit_d      = digit_q;
    anode_d      = anode_q;
    base_d       = base_q;
    pending_d    = pending_q;
    scroll_cnt_d = '0;
    char_d       = char_q;

    case (state_q)
      BLANK: begin
        if (slot_cnt_q == SLOT_W'(GUARD - 1)) begin
          state_d    = DRIVE;
          slot_cnt_d = '0;
          anode_d    = ANODE_OFF & ~(4'b0001 << digit_q);
        end
      end
      DRIVE: begin
        if (slot_cnt_q == SLOT_W'(REFRESH_DIV - GUARD - 1)) begin
          state_d    = BLANK;
          slot_cnt_d = '0;
          digit_d    = (digit_q == 2'(DIGITS - 1)) ? 2'd0 : digit_q + 2'd1;
          anode_d    = ANODE_OFF;
        end
      end
      default: begin
        state_d    = BLANK;
        slot_cnt_d = '0;
        anode_d    = ANODE_OFF;
      end
    endcase

    if (mode_auto && !scroll_tick) scroll_cnt_d = scroll_cnt_q + SCR_W'(1);

    // Base only moves at frame start so a frame never mixes two scroll positions;
    // a request landing in that same cycle is folded into this advance.
    if (frame_start_w) begin
      pending_d = 1'b0;
      if (pending_q || advance_req)
        base_d = IDX_W'(mod_add(32'(base_q), base_step, 32'(MSG_LEN)));
    end else if (advance_req) begin
      pending_d = 1'b1;
    end

    // Reloaded through every blank cycle so digit 0 picks up the freshly advanced base.
    if (state_d == BLANK)
      char_d = IDX_W'(mod_add(32'(base_d), 32'(digit_d), 32'(MSG_LEN)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= BLANK;
      slot_cnt_q   <= '0;
      digit_q      <= 2'd0;
      anode_q      <= ANODE_OFF;
      char_q       <= '0;
      base_q       <= '0;
      pending_q    <= 1'b0;
      scroll_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      digit_q      <= digit_d;
      anode_q      <= anode_d;
      char_q       <= char_d;
      base_q       <= base_d;
      pending_q    <= pending_d;
      scroll_cnt_q <= scroll_cnt_d;
    end
  end

  assign anode       = anode_q;
  assign digit_sel   = digit_q;
  assign char_index  = char_q;
  assign frame_start = frame_start_w;

endmodule

// File: tb/tb_display_scroll_sequencer.sv
// Directed bench for display_scroll_sequencer with MSG_LEN=6, REFRESH_DIV=8, GUARD=2, SCROLL_DIV=100.
module tb_display_scroll_sequencer;

  localparam int MSG_LEN     = 6;
  localparam int REFRESH_DIV = 8;
  localparam int GUARD       = 2;
  localparam int SCROLL_DIV  = 100;
  localparam int FRAME       = 4 * REFRESH_DIV;

  logic       clock       = 1'b0;
  logic       reset       = 1'b1;
  logic       step_button = 1'b0;
  logic       mode_auto   = 1'b0;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic [2:0] char_index;
  logic       frame_start;

  int vectors     = 0;
  int miscompares = 0;
  int pos         = 0;

  always #5 clock = ~clock;

  display_scroll_sequencer #(
    .MSG_LEN     (MSG_LEN),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD),
    .SCROLL_DIV  (SCROLL_DIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .step_button (step_button),
    .mode_auto   (mode_auto),
`ifdef SCROLL_REVERSE_EN
    .step_dir    (1'b0),
`endif
    .anode       (anode),
    .digit_sel   (digit_sel),
    .char_index  (char_index),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, pos);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    pos++;
  endtask

  task automatic goto_frame();
    while (pos % FRAME != 0) next_cycle();
  endtask

  // Walks one whole frame and checks every cycle against the slot timing and base b.
  task automatic check_frame(input int b);
    logic [3:0] exp_an;
    goto_frame();
    for (int c = 0; c < FRAME; c++) begin
      exp_an = 4'hF;
      if (c % REFRESH_DIV >= GUARD) exp_an[c / REFRESH_DIV] = 1'b0;
      check("anode", 32'(anode), 32'(exp_an));
      check("digit_sel", 32'(digit_sel), 32'(c / REFRESH_DIV));
      check("frame_start", 32'(frame_start), 32'(c == 0));
      if (c % REFRESH_DIV >= GUARD)
        check("char_index", 32'(char_index), 32'((b + c / REFRESH_DIV) % MSG_LEN));
      next_cycle();
    end
  endtask

  task automatic press(input int hold);
    step_button = 1'b1;
    repeat (hold) next_cycle();
    step_button = 1'b0;
    repeat (4) next_cycle();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_anode"}, 32'(anode), 32'h0000_000F);
    check({tag, "_digit"}, 32'(digit_sel), 32'd0);
    check({tag, "_char"}, 32'(char_index), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  // Ticks fall at 100k-1 after auto is enabled and land on the first frame start at or after them.
  function automatic int auto_advances(input int j);
    int n;
    n = 0;
    for (int k = 1; k <= 20; k++)
      if ((100 * k - 1 + FRAME - 1) / FRAME <= j) n++;
    return n;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held: outputs at reset values, frame_start suppressed.
    repeat (3) @(negedge clock);
    check_reset_vals("reset_hold");
    reset = 1'b0;
    #1;
    pos = 0;
    check("release_fs", 32'(frame_start), 32'd1);

    // Frame 0 after release: blank/drive timing and indices 0,1,2,3.
    check_frame(0);

    // One press held for 200 cycles gives exactly one advance at the next frame.
    repeat (3) next_cycle();
    step_button = 1'b1;
    repeat (5) check_frame(1);
    repeat (11) next_cycle();
    step_button = 1'b0;
    check_frame(1);

    // Four more presses bring base to 5, then one more wraps to 0.
    for (int i = 0; i < 4; i++) begin
      repeat (3) next_cycle();
      press(4);
      goto_frame();
    end
    check_frame(5);
    repeat (3) next_cycle();
    press(4);
    check_frame(0);

    // Two presses inside one frame collapse into a single advance.
    repeat (2) next_cycle();
    press(3);
    press(3);
    check_frame(1);

    // Auto mode: advances follow scroll ticks; toggling the button adds nothing.
    mode_auto = 1'b1;
    for (int j = 0; j < 31; j++) begin
      step_button = j[0];
      check_frame((1 + auto_advances(j)) % MSG_LEN);
    end
    step_button = 1'b0;
    // Leave auto mode after the tick at 999 but before its frame start: pending survives.
    repeat (10) next_cycle();
    mode_auto = 1'b0;
    check_frame((1 + auto_advances(32)) % MSG_LEN);

    // Reset during digit 2 drive with a pending request.
    repeat (3) next_cycle();
    press(4);
    repeat (9) next_cycle();
    check("pre_reset_anode", 32'(anode), 32'h0000_000B);
    check("pre_reset_digit", 32'(digit_sel), 32'd2);
    reset = 1'b1;
    step_button = 1'b1;
    next_cycle();
    check_reset_vals("mid_reset");
    repeat (2) next_cycle();
    reset = 1'b0;
    #1;
    pos = 0;
    // Pending was cleared and the held button produces no event.
    check_frame(0);
    check_frame(0);
    step_button = 1'b0;
    check_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
